uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter (serializer, parity, mux and TX FSM) between N byte requesters using round-robin arbitration.
- Latches the granted byte and its parity enable, then issues a one-cycle Data_Valid pulse to the transmitter.
- Tracks the transmitter's Busy output through the whole frame, then releases the grant.
- Sits between the requester clients and the UART TX top level, in the same clock domain.

Parameters:
- DATA_SIZE, 8, width of one transmitted byte.
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT, 16, maximum cycles to wait for TX_BUSY to rise after issue (used only with the optional feature).

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  synchronous, active-high reset.
- REQ_VALID  input  NUM_REQ  per-requester request; held high with stable data until the matching REQ_ACK.
- REQ_DATA  input  NUM_REQ*DATA_SIZE  packed bytes; requester i uses bits [i*DATA_SIZE +: DATA_SIZE].
- REQ_PAR_EN  input  NUM_REQ  per-requester parity enable for its frame.
- REQ_ACK  output  NUM_REQ  one-hot, one-cycle pulse: the byte was taken.
- TX_P_DATA  output  DATA_SIZE  registered byte to the transmitter.
- TX_DATA_VALID  output  1  one-cycle start pulse to the transmitter.
- TX_PAR_EN  output  1  registered parity enable to the transmitter.
- TX_BUSY  input  1  transmitter Busy (registered there; rises 2 cycles after TX_DATA_VALID).
- GRANT_ID  output  clog2(NUM_REQ)  index of the current or last granted requester.
- ARB_BUSY  output  1  high whenever the state is not IDLE.
- TX_ERR  output  1  one-cycle timeout pulse; tied 0 when the optional feature is off.

Behaviour:
- Reset (RST=1 at a clock edge): state=IDLE; TX_P_DATA=0; TX_PAR_EN=0; TX_DATA_VALID=0; REQ_ACK=0; GRANT_ID=0; ARB_BUSY=0; TX_ERR=0; last_grant=NUM_REQ-1, so requester 0 has first priority.
- Reset applied mid-frame aborts the arbiter immediately. The transmitter shares RST at top level.
- State IDLE:
  - If |REQ_VALID, pick the first set bit scanning from (last_grant+1) mod NUM_REQ upward with wrap-around.
  - On that edge, latch TX_P_DATA, TX_PAR_EN and GRANT_ID; go to ISSUE. Otherwise stay in IDLE.
- State ISSUE (exactly 1 cycle):
  - TX_DATA_VALID=1 and REQ_ACK[GRANT_ID]=1 in the same cycle.
  - last_grant<=GRANT_ID; go to WAIT_BUSY.
- State WAIT_BUSY: stay until TX_BUSY=1, then go to WAIT_DONE.
- State WAIT_DONE:
  - Stay while TX_BUSY=1; when TX_BUSY=0, go to IDLE.
  - A new grant decision is made in the following IDLE cycle, giving a minimum gap of 1 idle cycle between frames.
- TX_P_DATA and TX_PAR_EN hold stable from latch until the next grant; they are never changed while ARB_BUSY=1.
- Latency:
  - Request to TX_DATA_VALID: 2 cycles when idle (decision edge, then ISSUE).
  - Request to REQ_ACK: the same 2 cycles.
- Simultaneous requests: exactly one is granted per frame. The others keep waiting, and each waits at most NUM_REQ-1 frames.
- A requester dropping REQ_VALID after the grant edge does not cancel the frame; the ACK is still pulsed.
- A requester already granted and still valid after its ACK is treated as a new request and has lowest priority next round.
- TX_BUSY=1 seen while in IDLE is ignored; no grant occurs until it would be safe. The grant is suppressed while TX_BUSY=1.

Optional Feature:
- Macro: UART_TX_ARB_TIMEOUT_EN.
- With the macro:
  - A counter clears on entry to WAIT_BUSY and increments each cycle there.
  - If it reaches TIMEOUT with TX_BUSY still 0, pulse TX_ERR for 1 cycle and return to IDLE.
  - last_grant keeps the failed ID, so the next requester gets priority.
- Without the macro: no counter; WAIT_BUSY waits indefinitely; TX_ERR is constant 0.

Decomposition:
- Shared package/include (uart_tx_pkg) holds:
  - state encodings IDLE=2'b00, ISSUE=2'b01, WAIT_BUSY=2'b10, WAIT_DONE=2'b11;
  - default DATA_SIZE;
  - a clog2 helper function.
- One natural sub-module: uart_rr_pick, a combinational rotate-priority encoder.
  - Inputs: req vector and last_grant.
  - Outputs: found flag and winner index.
- The FSM, registers and timeout counter stay in uart_tx_arbiter.

Test Plan:
- Single request: REQ_VALID=4'b0010, byte 8'hA5, PAR_EN=1 → TX_DATA_VALID pulse 2 cycles later, TX_P_DATA=8'hA5, TX_PAR_EN=1, REQ_ACK=4'b0010 for one cycle, GRANT_ID=1, ARB_BUSY low again one cycle after TX_BUSY falls.
- Round-robin: all four requesters held valid with bytes 8'h10/8'h21/8'h32/8'h43 from reset → frames issued in order 0,1,2,3,0, each ACK one-hot, no requester ACKed twice before the others.
- Wrap-around: last_grant=3, REQ_VALID=4'b1001 → requester 0 granted before 3.
- Reset mid-frame: RST=1 during WAIT_DONE → next cycle all outputs 0, state IDLE; after release, requester 0 has priority again.
- Stable data: change REQ_DATA of the granted requester to 8'hFF during WAIT_DONE → TX_P_DATA unchanged until the next grant.
- Timeout (macro on, TIMEOUT=16): hold TX_BUSY=0 after issue → TX_ERR pulses exactly 16 cycles after entering WAIT_BUSY, state returns to IDLE; with the macro off, the arbiter stays in WAIT_BUSY.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared types and helpers for the UART TX requester arbiter.
// FSM state encoding, default byte width and a constant clog2.
package uart_tx_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        ISSUE     = 2'b01,
        WAIT_BUSY = 2'b10,
        WAIT_DONE = 2'b11
    } arb_state_e;

    localparam int DEF_DATA_SIZE = 8;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational rotate-priority encoder: the first set request
// strictly after last_grant, wrapping around, wins.
module uart_rr_pick
    import uart_tx_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW     = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     last_grant,
    output logic               found,
    output logic [IDW-1:0]     winner
);

    logic [IDW-1:0] idx;

    // Scan farthest-first so the nearest candidate overwrites.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = IDW'((int'(last_grant) + k) % NUM_REQ);
            if (req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ clients.
// Define UART_TX_ARB_TIMEOUT_EN to abort frames whose TX_BUSY never rises.
module uart_tx_arbiter
    import uart_tx_pkg::*;
#(
    parameter int DATA_SIZE = DEF_DATA_SIZE,
    parameter int NUM_REQ   = 4,
    parameter int TIMEOUT   = 16,
    localparam int IDW      = clog2(NUM_REQ)
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [NUM_REQ-1:0]           REQ_VALID,
    input  logic [NUM_REQ*DATA_SIZE-1:0] REQ_DATA,
    input  logic [NUM_REQ-1:0]           REQ_PAR_EN,
    output logic [NUM_REQ-1:0]           REQ_ACK,
    output logic [DATA_SIZE-1:0]         TX_P_DATA,
    output logic                         TX_DATA_VALID,
    output logic                         TX_PAR_EN,
    input  logic                         TX_BUSY,
    output logic [IDW-1:0]               GRANT_ID,
    output logic                         ARB_BUSY,
    output logic                         TX_ERR
);

    arb_state_e           state;
    arb_state_e           state_nxt;
    logic [IDW-1:0]       last_grant;
    logic [IDW-1:0]       grant_id;
    logic [DATA_SIZE-1:0] tx_p_data;
    logic                 tx_par_en;
    logic                 pick_found;
    logic [IDW-1:0]       pick_id;
    logic                 grant_go;
    logic                 timeout_hit;

    uart_rr_pick #(
        .NUM_REQ    (NUM_REQ),
        .IDW        (IDW)
    ) u_pick (
        .req        (REQ_VALID),
        .last_grant (last_grant),
        .found      (pick_found),
        .winner     (pick_id)
    );

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int CW = clog2(TIMEOUT + 1);

    logic [CW-1:0] wait_cnt;
    logic          tx_err;

    // Counter sits at zero outside WAIT_BUSY, so it is clear on entry.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wait_cnt <= '0;
            tx_err   <= 1'b0;
        end else begin
            tx_err <= timeout_hit;
            if (state != WAIT_BUSY) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    assign timeout_hit = (state == WAIT_BUSY) && !TX_BUSY
                       && (wait_cnt == CW'(TIMEOUT - 1));
    assign TX_ERR      = tx_err;
`else
    assign timeout_hit = 1'b0;
    assign TX_ERR      = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        grant_go      = 1'b0;
        TX_DATA_VALID = 1'b0;
        REQ_ACK       = '0;
        ARB_BUSY      = (state != IDLE);
        unique case (state)
            IDLE: begin
                // Never start a frame while the transmitter claims busy.
                if (pick_found && !TX_BUSY) begin
                    grant_go  = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                TX_DATA_VALID     = 1'b1;
                REQ_ACK[grant_id] = 1'b1;
                state_nxt         = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (TX_BUSY) begin
                    state_nxt = WAIT_DONE;
                end else if (timeout_hit) begin
                    state_nxt = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!TX_BUSY) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            tx_p_data  <= '0;
            tx_par_en  <= 1'b0;
            grant_id   <= '0;
            last_grant <= IDW'(NUM_REQ - 1);
        end else begin
            if (grant_go) begin
                tx_p_data <= REQ_DATA[int'(pick_id)*DATA_SIZE +: DATA_SIZE];
                tx_par_en <= REQ_PAR_EN[pick_id];
                grant_id  <= pick_id;
            end
            if (state == ISSUE) begin
                last_grant <= grant_id;
            end
        end
    end

    assign TX_P_DATA = tx_p_data;
    assign TX_PAR_EN = tx_par_en;
    assign GRANT_ID  = grant_id;

endmodule
